// File: rtl/ct_spsram_256x144_acc_ctrl_pkg.sv
// Shared types and constants for the 256x144 single-port SRAM access controller.
package ct_spsram_256x144_acc_ctrl_pkg;

    localparam int unsigned ACC_ADDR_WIDTH = 8;
    localparam int unsigned ACC_DATA_WIDTH = 144;
    localparam int unsigned SRAM_DEPTH     = 2 ** ACC_ADDR_WIDTH;
    localparam int unsigned RSP_DEPTH      = 2;
    localparam int unsigned RSP_CNT_WIDTH  = $clog2(RSP_DEPTH + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/ct_spsram_256x144_acc_ctrl_if.sv
// Request/response stream plus SRAM macro pins of the access controller.
interface ct_spsram_256x144_acc_ctrl_if
    import ct_spsram_256x144_acc_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ACC_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ACC_DATA_WIDTH
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  init_done;
    logic                  sram_cen;
    logic                  sram_gwen;
    logic [DATA_WIDTH-1:0] sram_wen;
    logic [ADDR_WIDTH-1:0] sram_a;
    logic [DATA_WIDTH-1:0] sram_d;
    logic [DATA_WIDTH-1:0] sram_q;

    // Requester and SRAM macro side
    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        input  req_rdy, rsp_vld, rsp_data, init_done,
        input  sram_cen, sram_gwen, sram_wen, sram_a, sram_d
    );

    // Controller side
    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy, sram_q,
        output req_rdy, rsp_vld, rsp_data, init_done,
        output sram_cen, sram_gwen, sram_wen, sram_a, sram_d
    );

endinterface

// File: rtl/ct_spsram_rsp_fifo.sv
// Two-entry read-response FIFO; the head entry is a register that feeds rsp_data directly.
module ct_spsram_rsp_fifo
    import ct_spsram_256x144_acc_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ACC_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [RSP_CNT_WIDTH-1:0] cnt,
    output logic [DATA_WIDTH-1:0]    head
);

    localparam logic [RSP_CNT_WIDTH-1:0] CNT_ONE  = RSP_CNT_WIDTH'(1);
    localparam logic [RSP_CNT_WIDTH-1:0] CNT_FULL = RSP_CNT_WIDTH'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] tail;

    // Pop shifts tail into head; a push lands in the first free slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == '0) begin
                        head <= push_data;
                    end else if (cnt == CNT_ONE) begin
                        tail <= push_data;
                    end
                    if (cnt != CNT_FULL) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - CNT_ONE;
                end
                2'b11: begin
                    if (cnt == CNT_ONE) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && !pop && cnt == CNT_FULL)
    );

endmodule

// File: rtl/ct_spsram_256x144_acc_ctrl.sv
// Access controller for the 256x144 single-port SRAM: zero-fill after reset, then
// request-to-CEN/GWEN/WEN translation with credit-limited read responses.
module ct_spsram_256x144_acc_ctrl
    import ct_spsram_256x144_acc_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ACC_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = ACC_DATA_WIDTH
) (
    input logic                          forever_cpuclk,
    input logic                          cpurst_b,
    ct_spsram_256x144_acc_ctrl_if.slave  bus
);

    localparam int unsigned OCC_WIDTH = RSP_CNT_WIDTH + 1;

    acc_state_e              state_q;
    acc_state_e              state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q;
    logic [ADDR_WIDTH-1:0]   init_cnt_d;
    logic                    rd_inflight_q;
    logic [ADDR_WIDTH-1:0]   a_hold_q;
    logic [DATA_WIDTH-1:0]   d_hold_q;
    logic [RSP_CNT_WIDTH-1:0] fifo_cnt;
    logic [DATA_WIDTH-1:0]   fifo_head;
    logic                    rsp_vld;
    logic                    rsp_pop;
    logic [OCC_WIDTH-1:0]    occ_c;
    logic                    req_rdy_c;
    logic                    fire_c;
    logic                    sram_cen_c;
    logic                    sram_gwen_c;
    logic [DATA_WIDTH-1:0]   sram_wen_c;
    logic [ADDR_WIDTH-1:0]   sram_a_c;
    logic [DATA_WIDTH-1:0]   sram_d_c;

    assign rsp_vld = (fifo_cnt != '0);
    assign rsp_pop = rsp_vld & bus.rsp_rdy;

    // Slots already committed: queued responses plus the read still in the macro
    assign occ_c = OCC_WIDTH'(fifo_cnt) + OCC_WIDTH'(rd_inflight_q) - OCC_WIDTH'(rsp_pop);

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        req_rdy_c   = 1'b0;
        fire_c      = 1'b0;
        sram_cen_c  = 1'b1;
        sram_gwen_c = 1'b1;
        sram_wen_c  = '1;
        sram_a_c    = a_hold_q;
        sram_d_c    = d_hold_q;
        case (state_q)
            ST_INIT: begin
                sram_cen_c  = 1'b0;
                sram_gwen_c = 1'b0;
                sram_wen_c  = '0;
                sram_a_c    = init_cnt_q;
                sram_d_c    = '0;
                init_cnt_d  = init_cnt_q + ADDR_WIDTH'(1);
                if (&init_cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                req_rdy_c = (occ_c < OCC_WIDTH'(RSP_DEPTH));
                fire_c    = bus.req_vld & req_rdy_c;
                if (fire_c) begin
                    sram_cen_c  = 1'b0;
                    sram_gwen_c = ~bus.req_wr;
                    sram_wen_c  = bus.req_wr ? ~bus.req_wmask : '1;
                    sram_a_c    = bus.req_addr;
                    sram_d_c    = bus.req_wdata;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Read tracking and last-driven address/data so idle cycles do not toggle the macro pins
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_inflight_q <= 1'b0;
            a_hold_q      <= '0;
            d_hold_q      <= '0;
        end else begin
            rd_inflight_q <= fire_c & ~bus.req_wr;
            a_hold_q      <= sram_a_c;
            d_hold_q      <= sram_d_c;
        end
    end

    ct_spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .push      (rd_inflight_q),
        .push_data (bus.sram_q),
        .pop       (rsp_pop),
        .cnt       (fifo_cnt),
        .head      (fifo_head)
    );

    assign bus.req_rdy   = req_rdy_c;
    assign bus.rsp_vld   = rsp_vld;
    assign bus.rsp_data  = fifo_head;
    assign bus.init_done = (state_q == ST_RUN);
    assign bus.sram_cen  = sram_cen_c;
    assign bus.sram_gwen = sram_gwen_c;
    assign bus.sram_wen  = sram_wen_c;
    assign bus.sram_a    = sram_a_c;
    assign bus.sram_d    = sram_d_c;

endmodule

// File: tb/tb_ct_spsram_256x144_acc_ctrl.sv
// Directed bench for the SRAM access controller with a behavioural 256x144 macro attached.
module tb_ct_spsram_256x144_acc_ctrl;
    import ct_spsram_256x144_acc_ctrl_pkg::*;

    localparam int unsigned AW = ACC_ADDR_WIDTH;
    localparam int unsigned DW = ACC_DATA_WIDTH;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] wmask;
        logic [DW-1:0] exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    ct_spsram_256x144_acc_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ct_spsram_256x144_acc_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .bus            (bus)
    );

    // Behavioural macro: masked write, or registered read data one cycle after issue
    logic [DW-1:0] mem [0:SRAM_DEPTH-1];
    always @(posedge clk) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_gwen) begin
                mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
            end else begin
                bus.sram_q <= mem[bus.sram_a];
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic release_and_check_init(input string nm);
        @(negedge clk);
        rst_b = 1'b1;
        for (int k = 0; k < 256; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk(nm, DW'({bus.sram_cen, bus.sram_gwen, |bus.sram_wen, bus.sram_a, |bus.sram_d,
                         bus.req_rdy, bus.init_done, bus.rsp_vld}),
                DW'({3'b000, 8'(k), 4'b0000}));
        end
        @(negedge clk);
        #1;
        chk({nm, "_done"}, DW'({bus.init_done, bus.req_rdy, bus.sram_cen, bus.sram_gwen}), DW'(4'b1111));
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
        @(negedge clk);
        bus.req_vld = 1'b1; bus.req_wr = 1'b1; bus.req_addr = a; bus.req_wdata = d; bus.req_wmask = m;
        #1;
        chk("wr_ctl", DW'({bus.req_rdy, bus.sram_cen, bus.sram_gwen, bus.sram_a}), DW'({3'b100, a}));
        chk("wr_wen", bus.sram_wen, ~m);
        chk("wr_d", bus.sram_d, d);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
        @(negedge clk);
        bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = a; bus.rsp_rdy = 1'b1;
        #1;
        chk({nm, "_issue"}, DW'({bus.req_rdy, bus.sram_cen, bus.sram_gwen, &bus.sram_wen, bus.sram_a}),
            DW'({4'b1011, a}));
        @(negedge clk);
        bus.req_vld = 1'b0;
        #1;
        chk({nm, "_vld_n1"}, DW'(bus.rsp_vld), DW'(1'b0));
        @(negedge clk);
        #1;
        chk({nm, "_vld_n2"}, DW'(bus.rsp_vld), DW'(1'b1));
        chk({nm, "_data"}, bus.rsp_data, exp);
    endtask

    vec_t          vecs [9];
    logic [DW-1:0] ones;
    logic [DW-1:0] pat;
    logic [DW-1:0] lo_mask;
    int            acc;

    initial begin
        ones    = '1;
        pat     = {4{36'h123456789}};
        lo_mask = {{72{1'b0}}, {72{1'b1}}};
        for (int i = 0; i < int'(SRAM_DEPTH); i++) mem[i] = {4{36'hDEADBEEF5}};
        bus.req_vld = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_rdy = 1'b1;

        vecs[0] = '{1'b0, 8'h7F, '0,  '0,      '0};
        vecs[1] = '{1'b1, 8'h10, ones, ones,   '0};
        vecs[2] = '{1'b0, 8'h10, '0,  '0,      ones};
        vecs[3] = '{1'b1, 8'h10, '0,  lo_mask, '0};
        vecs[4] = '{1'b0, 8'h10, '0,  '0,      ~lo_mask};
        vecs[5] = '{1'b1, 8'h20, pat, '0,      '0};
        vecs[6] = '{1'b0, 8'h20, '0,  '0,      '0};
        vecs[7] = '{1'b1, 8'h21, pat, ones,    '0};
        vecs[8] = '{1'b0, 8'h21, '0,  '0,      pat};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_outs", DW'({bus.req_rdy, bus.rsp_vld, bus.init_done}), DW'(3'b000));
        release_and_check_init("init1");

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            else do_read(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Idle: controls deasserted, address/data hold the last issue
        @(negedge clk);
        bus.req_vld = 1'b0;
        #1;
        chk("idle_ctl", DW'({bus.sram_cen, bus.sram_gwen, &bus.sram_wen, bus.sram_a}), DW'({3'b111, 8'h21}));
        chk("idle_d", bus.sram_d, pat);

        // Back-to-back reads with rsp_rdy held high
        for (int i = 0; i < 8; i++) do_write(AW'(i), DW'(i + 1), ones);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (c < 8) begin
                bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = AW'(c);
            end else begin
                bus.req_vld = 1'b0;
            end
            #1;
            if (c < 8) chk("b2b_rdy", DW'(bus.req_rdy), DW'(1'b1));
            if (c >= 2 && c < 10) begin
                chk("b2b_vld", DW'(bus.rsp_vld), DW'(1'b1));
                chk("b2b_data", bus.rsp_data, DW'(c - 1));
            end
            if (c == 10) chk("b2b_drained", DW'(bus.rsp_vld), DW'(1'b0));
        end

        // Backpressure: only two reads fit with rsp_rdy low
        bus.rsp_rdy = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = AW'(acc);
            #1;
            if (bus.req_rdy) acc++;
            if (c >= 2) chk("bp_stall", DW'({bus.req_rdy, bus.sram_cen}), DW'(2'b01));
        end
        chk("bp_accepts", DW'(acc), DW'(2));
        chk("bp_head", bus.rsp_data, DW'(1));
        @(negedge clk);
        bus.rsp_rdy = 1'b1; bus.req_addr = AW'(2);
        #1;
        chk("bp_resume", DW'({bus.req_rdy, bus.rsp_vld}), DW'(2'b11));
        chk("bp_d0", bus.rsp_data, DW'(1));
        @(negedge clk);
        bus.req_vld = 1'b0;
        #1;
        chk("bp_d1", DW'({bus.rsp_vld, bus.rsp_data}), DW'({1'b1, 144'd2}));
        @(negedge clk);
        #1;
        chk("bp_d2", DW'({bus.rsp_vld, bus.rsp_data}), DW'({1'b1, 144'd3}));
        @(negedge clk);
        #1;
        chk("bp_empty", DW'(bus.rsp_vld), DW'(1'b0));

        // Reset with one read in flight and one FIFO entry
        bus.rsp_rdy = 1'b0;
        @(negedge clk);
        bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = AW'(5);
        #1;
        chk("mr_rd0", DW'(bus.req_rdy), DW'(1'b1));
        @(negedge clk);
        bus.req_addr = AW'(6);
        #1;
        chk("mr_rd1", DW'(bus.req_rdy), DW'(1'b1));
        @(negedge clk);
        bus.req_vld = 1'b0;
        #1;
        chk("mr_pre", DW'({bus.rsp_vld, bus.rsp_data}), DW'({1'b1, 144'd6}));
        rst_b = 1'b0;
        #1;
        chk("mr_rst", DW'({bus.rsp_vld, bus.req_rdy, bus.init_done}), DW'(3'b000));
        repeat (2) @(negedge clk);
        bus.rsp_rdy = 1'b1;
        release_and_check_init("init2");
        do_read(AW'(5), '0, "rz5");
        do_read(8'h10, '0, "rz10");
        do_read(8'h21, '0, "rz21");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
